// File: rtl/taillight_seq.sv
// taillight_seq: sequential turn-signal / hazard tail-light controller.
// Each side has LAMPS lamps. The sequence advances once per TICK_DIV clk cycles.
// Optional feature: define TAILLIGHT_BRAKE_EN to add a brake input. Brake lights
// every lamp on a side that is not running a turn sequence, and it does so
// without waiting for a tick.
module taillight_seq #(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 12500000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               left,
    input  logic               right,
    input  logic               hazard,
`ifdef TAILLIGHT_BRAKE_EN
    input  logic               brake,
`endif
    output logic [2*LAMPS-1:0] lights,
    output logic               busy
);

    localparam int CW = $clog2(TICK_DIV);
    localparam int SW = $clog2(LAMPS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);
    localparam logic [SW-1:0] LAST    = SW'(LAMPS);
    localparam logic [LAMPS-1:0] SIDE_OFF = '0;

    typedef enum logic [2:0] {
        IDLE,
        LEFT,
        RIGHT,
        HAZ_ON,
        HAZ_OFF
    } state_t;

    state_t                 state;
    logic [SW-1:0]          step;
    logic [CW-1:0]          cnt;
    logic                   tick;
    logic                   haz_req;
    logic [2*LAMPS-1:0]     lights_q;
    logic                   busy_q;

    // Build a mask with the k innermost lamps of one side lit.
    // Bit 0 of either side field is the innermost lamp.
    function automatic logic [LAMPS-1:0] fill(input logic [SW-1:0] k);
        logic [LAMPS-1:0] m;
        m = '0;
        for (int i = 0; i < LAMPS; i++) begin
            m[i] = (SW'(i) < k);
        end
        return m;
    endfunction

    assign tick    = (cnt == CNT_MAX);
    assign haz_req = hazard | (left & right);

    // Free-running step divider; tick marks the last cycle of each step.
    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Sequencer. It samples requests only on tick and loads the outputs
    // alongside the state, so the outputs are registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            step     <= '0;
            lights_q <= '0;
            busy_q   <= 1'b0;
        end else if (tick) begin
            case (state)
                IDLE: begin
                    if (haz_req) begin
                        state    <= HAZ_ON;
                        lights_q <= '1;
                        busy_q   <= 1'b1;
                    end else if (left) begin
                        state    <= LEFT;
                        step     <= SW'(1);
                        lights_q <= {fill(SW'(1)), SIDE_OFF};
                        busy_q   <= 1'b1;
                    end else if (right) begin
                        state    <= RIGHT;
                        step     <= SW'(1);
                        lights_q <= {SIDE_OFF, fill(SW'(1))};
                        busy_q   <= 1'b1;
                    end
                end
                LEFT, RIGHT: begin
                    // Turn requests are ignored mid-run; only hazard can abort.
                    if (haz_req) begin
                        state    <= HAZ_ON;
                        step     <= '0;
                        lights_q <= '1;
                        busy_q   <= 1'b1;
                    end else if (step == LAST) begin
                        state    <= IDLE;
                        step     <= '0;
                        lights_q <= '0;
                        busy_q   <= 1'b0;
                    end else begin
                        step     <= step + SW'(1);
                        lights_q <= (state == LEFT) ? {fill(step + SW'(1)), SIDE_OFF}
                                                    : {SIDE_OFF, fill(step + SW'(1))};
                    end
                end
                HAZ_ON: begin
                    state    <= haz_req ? HAZ_OFF : IDLE;
                    lights_q <= '0;
                    busy_q   <= haz_req;
                end
                HAZ_OFF: begin
                    state    <= haz_req ? HAZ_ON : IDLE;
                    lights_q <= haz_req ? '1 : '0;
                    busy_q   <= haz_req;
                end
                default: begin
                    state    <= IDLE;
                    step     <= '0;
                    lights_q <= '0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef TAILLIGHT_BRAKE_EN
    logic [2*LAMPS-1:0] brake_mask;

    // Brake overlay: light steady every side that is not running a sequence.
    // NOTE: the combinational block assigns a default first, so no latch is inferred.
    always_comb begin
        brake_mask = '1;
        if (state == LEFT) begin
            brake_mask = {SIDE_OFF, ~SIDE_OFF};
        end else if (state == RIGHT) begin
            brake_mask = {~SIDE_OFF, SIDE_OFF};
        end
        if (!brake || !rst) begin
            brake_mask = '0;
        end
    end

    assign lights = lights_q | brake_mask;
`else
    assign lights = lights_q;
`endif

    assign busy = busy_q;

endmodule

// File: tb/tb_taillight_seq.sv
// Directed testbench for taillight_seq with LAMPS=3 and TICK_DIV=4.
// Build with TAILLIGHT_BRAKE_EN defined to also exercise the brake overlay.
module tb_taillight_seq;

    localparam int LAMPS = 3;
    localparam int TD    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       left = 1'b0;
    logic       right = 1'b0;
    logic       hazard = 1'b0;
`ifdef TAILLIGHT_BRAKE_EN
    logic       brake = 1'b0;
`endif
    logic [5:0] lights;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    taillight_seq #(.LAMPS(LAMPS), .TICK_DIV(TD)) dut (
        .clk    (clk),
        .rst    (rst),
        .left   (left),
        .right  (right),
        .hazard (hazard),
`ifdef TAILLIGHT_BRAKE_EN
        .brake  (brake),
`endif
        .lights (lights),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Assert reset for two clocks, then release it 1 time unit after a rising edge.
    // The first tick update then lands on the 4th rising edge after release.
    task automatic do_reset();
        left   = 1'b0;
        right  = 1'b0;
        hazard = 1'b0;
        rst    = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Advance to 1 time unit after the next tick update edge.
    task automatic step_tick();
        repeat (TD) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        checks++;
        if (lights !== 6'b000000 || busy !== 1'b0) begin
            $display("FAIL reset_hold lights=%b busy=%b expected lights=000000 busy=0", lights, busy);
            failures++;
        end
        do_reset();
        left = 1'b1;
        repeat (TD - 1) @(posedge clk);
        #1;
        checks++;
        if (lights !== 6'b000000 || busy !== 1'b0) begin
            $display("FAIL reset_early_tick lights=%b busy=%b expected lights=000000 busy=0", lights, busy);
            failures++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (lights !== 6'b001000 || busy !== 1'b1) begin
            $display("FAIL reset_first_tick lights=%b busy=%b expected lights=001000 busy=1", lights, busy);
            failures++;
        end
    endtask

    task automatic test_left_hold();
        logic [5:0] exp_l [5] = '{6'b001000, 6'b011000, 6'b111000, 6'b000000, 6'b001000};
        logic       exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        left = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_tick();
            checks++;
            if (lights !== exp_l[i] || busy !== exp_b[i]) begin
                $display("FAIL left_hold[%0d] lights=%b busy=%b expected lights=%b busy=%b",
                         i, lights, busy, exp_l[i], exp_b[i]);
                failures++;
            end
        end
        left = 1'b0;
    endtask

    task automatic test_right_once();
        logic [5:0] exp_l [5] = '{6'b000001, 6'b000011, 6'b000111, 6'b000000, 6'b000000};
        logic       exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        right = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_tick();
            right = 1'b0;
            checks++;
            if (lights !== exp_l[i] || busy !== exp_b[i]) begin
                $display("FAIL right_once[%0d] lights=%b busy=%b expected lights=%b busy=%b",
                         i, lights, busy, exp_l[i], exp_b[i]);
                failures++;
            end
        end
    endtask

    task automatic test_hazard();
        logic [5:0] exp_l [5] = '{6'b111111, 6'b000000, 6'b111111, 6'b000000, 6'b000000};
        logic       exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        left  = 1'b1;
        right = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_tick();
            // Drop both requests once HAZ_ON is showing for the second time.
            if (i == 2) begin
                left  = 1'b0;
                right = 1'b0;
            end
            checks++;
            if (lights !== exp_l[i] || busy !== exp_b[i]) begin
                $display("FAIL hazard[%0d] lights=%b busy=%b expected lights=%b busy=%b",
                         i, lights, busy, exp_l[i], exp_b[i]);
                failures++;
            end
        end
    endtask

    task automatic test_ignore_opposite();
        logic [5:0] exp_l [5] = '{6'b001000, 6'b011000, 6'b111000, 6'b000000, 6'b000000};
        do_reset();
        left = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step_tick();
            if (i == 0) left = 1'b0;
            if (i == 1) right = 1'b1;
            if (i == 3) right = 1'b0;
            checks++;
            if (lights !== exp_l[i]) begin
                $display("FAIL ignore_opposite[%0d] lights=%b expected %b", i, lights, exp_l[i]);
                failures++;
            end
        end
    endtask

    task automatic test_hazard_abort();
        do_reset();
        left = 1'b1;
        step_tick();
        step_tick();
        checks++;
        if (lights !== 6'b011000) begin
            $display("FAIL abort_step2 lights=%b expected 011000", lights);
            failures++;
        end
        left   = 1'b0;
        hazard = 1'b1;
        step_tick();
        checks++;
        if (lights !== 6'b111111 || busy !== 1'b1) begin
            $display("FAIL abort_haz lights=%b busy=%b expected lights=111111 busy=1", lights, busy);
            failures++;
        end
        hazard = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        left = 1'b1;
        step_tick();
        step_tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (lights !== 6'b000000 || busy !== 1'b0) begin
            $display("FAIL async_reset lights=%b busy=%b expected lights=000000 busy=0", lights, busy);
            failures++;
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (TD - 1) @(posedge clk);
        #1;
        checks++;
        if (lights !== 6'b000000) begin
            $display("FAIL async_early_tick lights=%b expected 000000", lights);
            failures++;
        end
        @(posedge clk);
        #1;
        checks++;
        if (lights !== 6'b001000) begin
            $display("FAIL async_first_tick lights=%b expected 001000", lights);
            failures++;
        end
        left = 1'b0;
    endtask

    task automatic test_pulse_lost();
        do_reset();
        @(posedge clk);
        #1 left = 1'b1;
        @(posedge clk);
        #1 left = 1'b0;
        repeat (TD - 2) @(posedge clk);
        #1;
        checks++;
        if (lights !== 6'b000000 || busy !== 1'b0) begin
            $display("FAIL pulse_lost lights=%b busy=%b expected lights=000000 busy=0", lights, busy);
            failures++;
        end
    endtask

`ifdef TAILLIGHT_BRAKE_EN
    task automatic test_brake();
        do_reset();
        left = 1'b1;
        step_tick();
        left  = 1'b0;
        brake = 1'b1;
        #1;
        checks++;
        if (lights !== 6'b001111) begin
            $display("FAIL brake_left1 lights=%b expected 001111", lights);
            failures++;
        end
        brake = 1'b0;
        do_reset();
        #1 brake = 1'b1;
        #1;
        checks++;
        if (lights !== 6'b111111 || busy !== 1'b0) begin
            $display("FAIL brake_idle lights=%b busy=%b expected lights=111111 busy=0", lights, busy);
            failures++;
        end
        brake  = 1'b0;
        hazard = 1'b1;
        step_tick();
        step_tick();
        brake = 1'b1;
        #1;
        checks++;
        if (lights !== 6'b111111 || busy !== 1'b1) begin
            $display("FAIL brake_haz_off lights=%b busy=%b expected lights=111111 busy=1", lights, busy);
            failures++;
        end
        brake  = 1'b0;
        hazard = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_left_hold();
        test_right_once();
        test_hazard();
        test_ignore_opposite();
        test_hazard_abort();
        test_async_reset();
        test_pulse_lost();
`ifdef TAILLIGHT_BRAKE_EN
        test_brake();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/taillight_seq.md
TAILLIGHT_SEQ -- requirements
Module: taillight_seq

Interface
REQ-001 Parameter LAMPS, default 3, SHALL set lamps per side; legal range 2..8.
REQ-002 Parameter TICK_DIV, default 12500000, SHALL set clk cycles per sequence step; legal range 2..2^24.
REQ-003 clk  input  1  SHALL be the single system clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 left  input  1  SHALL be the left-turn request, synchronous to clk.
REQ-006 right  input  1  SHALL be the right-turn request, synchronous to clk.
REQ-007 hazard  input  1  SHALL be the hazard request, synchronous to clk.
REQ-008 lights  output  2*LAMPS  SHALL drive the lamps: [LAMPS-1:0] is the right side with bit 0 innermost; [2*LAMPS-1:LAMPS] is the left side with bit LAMPS innermost.
REQ-009 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-010 An internal tick counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high for the one cycle where count==TICK_DIV-1.
REQ-011 The state register SHALL change only on cycles where tick is high.
REQ-012 States SHALL be IDLE, LEFT, RIGHT, HAZ_ON and HAZ_OFF; LEFT and RIGHT carry a step counter 1..LAMPS sized $clog2(LAMPS+1).
REQ-013 In IDLE on tick, request priority SHALL be: (hazard or (left and right)) -> HAZ_ON; else left -> LEFT step 1; else right -> RIGHT step 1; else stay in IDLE.
REQ-014 In LEFT/RIGHT on tick, step SHALL increment; at step==LAMPS the next tick SHALL return to IDLE whether or not the request is still held.
REQ-015 A held left or right SHALL restart its sequence from IDLE at the next tick, so the sequence repeats with one dark step between runs.
REQ-016 A left or right request arriving during a running sequence SHALL be ignored, including a request for the opposite direction.
REQ-017 Hazard (or left and right together) during LEFT/RIGHT SHALL abort the sequence to HAZ_ON at the next tick.
REQ-018 HAZ_ON and HAZ_OFF SHALL alternate each tick while the hazard condition holds; if the condition is low at a tick, the state SHALL go to IDLE from either state.
REQ-019 Lights in LEFT step k SHALL be the k innermost left lamps on and all right lamps off; RIGHT is the mirror image.
REQ-020 Lights in HAZ_ON SHALL be all 2*LAMPS bits set; HAZ_OFF and IDLE SHALL be all bits clear, except as modified by REQ-026.
REQ-021 lights and busy SHALL be decoded from registered state only and valid in the cycle after the tick edge; inputs SHALL have no combinational path to outputs.
REQ-022 Inputs SHALL be sampled only on tick cycles; pulses between ticks SHALL be lost.

Reset
REQ-023 Asserting rst low SHALL immediately force state=IDLE, step=0, tick count=0, lights=0 and busy=0, including mid-sequence.
REQ-024 After rst deasserts, the first tick SHALL occur TICK_DIV cycles later.

Configuration
REQ-025 Macro TAILLIGHT_BRAKE_EN SHALL, when defined, add the port brake  input  1.
REQ-026 With TAILLIGHT_BRAKE_EN defined and brake high, lamps on a side not in an active LEFT/RIGHT sequence SHALL be lit steady; in HAZ_OFF all lamps SHALL be lit; brake SHALL act combinationally from its input with no tick wait, and SHALL NOT alter state transitions.
REQ-027 Without TAILLIGHT_BRAKE_EN, the brake port and its logic SHALL be absent and lights SHALL follow REQ-019 and REQ-020 only.

Verification (LAMPS=3, TICK_DIV=4)
REQ-028 Reset, then hold left=1 -> at successive ticks lights = 001000, 011000, 111000, 000000, 001000; busy low only during the 000000 step.
REQ-029 Hold right=1 for one tick then release -> lights = 000001, 000011, 000111, 000000, and the state then stays in IDLE.
REQ-030 Raise left and right together in IDLE -> lights alternate 111111 and 000000 each tick; drop both while in HAZ_ON -> 000000 with busy=0 at the next tick.
REQ-031 Start left, then assert right at step 2 -> right is ignored and the left sequence completes; assert hazard at step 2 instead -> 111111 at the next tick.
REQ-032 Pull rst low during LEFT step 2 -> lights=000000 and busy=0 within the same cycle, with no clk edge; after release the first tick occurs 4 cycles later.
REQ-033 With TAILLIGHT_BRAKE_EN defined, brake=1 during LEFT step 1 -> lights=001111; brake=1 in IDLE -> 111111; brake=1 in HAZ_OFF -> 111111.
